hazard_stall_ctrl: RTL

Pipeline interlock unit for the 5-stage core. It sits beside the forwarding controller and decides, each cycle, whether the instruction in ID can proceed using forwarding alone or must be held. When it holds the instruction, it freezes PC and IF/ID and inserts a bubble into ID/EX. It also owns the multi-cycle multiply/divide busy sequencer, so HI/LO consumers stall until the MDU result exists.

---
 rtl/hazard_stall_ctrl_if.sv | 37 +++
 rtl/hazard_stall_ctrl.sv | 85 ++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl_if.sv
// rtl/hazard_stall_ctrl_if.sv - hazard/MDU interlock signal bundle between pipeline and stall controller
interface hazard_stall_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic [1:0]       id_rs_tuse;
    logic [1:0]       id_rt_tuse;
    logic [4:0]       ex_dst;
    logic [4:0]       mem_dst;
    logic [1:0]       ex_tnew;
    logic [1:0]       mem_tnew;
    logic             id_is_md;
    logic             ex_md_start;
    logic             ex_md_is_div;
    logic             md_cancel;
    logic             pc_en;
    logic             ifid_en;
    logic             idex_flush;
    logic             md_busy;
    logic             md_done;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output id_rs, id_rt, id_rs_tuse, id_rt_tuse,
        output ex_dst, mem_dst, ex_tnew, mem_tnew,
        output id_is_md, ex_md_start, ex_md_is_div, md_cancel,
        input  pc_en, ifid_en, idex_flush, md_busy, md_done, stall_cycles
    );

    modport slave (
        input  id_rs, id_rt, id_rs_tuse, id_rt_tuse,
        input  ex_dst, mem_dst, ex_tnew, mem_tnew,
        input  id_is_md, ex_md_start, ex_md_is_div, md_cancel,
        output pc_en, ifid_en, idex_flush, md_busy, md_done, stall_cycles
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - pipeline interlock: data-hazard stall, MDU busy sequencer, stall counter
module hazard_stall_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    hazard_stall_ctrl_if.slave bus
);
    localparam int MAXC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CW   = (MAXC > 2) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} md_state_t;

    md_state_t        state, state_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [CNT_W-1:0] stall_cnt;
    logic             data_stall, md_stall, stall;

    // A tuse of 3 means the operand is unused; tnew never exceeds 2 but the guard keeps intent explicit.
    function automatic logic hit(input logic [4:0] src, input logic [1:0] tuse,
                                 input logic [4:0] dst, input logic [1:0] tnew);
        return (tuse != 2'd3) && (dst != 5'd0) && (dst == src) && (tuse < tnew);
    endfunction

    always_comb begin
        data_stall = hit(bus.id_rs, bus.id_rs_tuse, bus.ex_dst,  bus.ex_tnew)
                   | hit(bus.id_rs, bus.id_rs_tuse, bus.mem_dst, bus.mem_tnew)
                   | hit(bus.id_rt, bus.id_rt_tuse, bus.ex_dst,  bus.ex_tnew)
                   | hit(bus.id_rt, bus.id_rt_tuse, bus.mem_dst, bus.mem_tnew);
        md_stall   = bus.id_is_md && (bus.ex_md_start || (state == S_BUSY)) && !bus.md_cancel;
        stall      = data_stall | md_stall;
    end

    assign bus.pc_en        = !stall;
    assign bus.ifid_en      = !stall;
    assign bus.idex_flush   = stall;
    assign bus.md_busy      = (state == S_BUSY);
    assign bus.md_done      = (state == S_DONE);
    assign bus.stall_cycles = stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Starts arriving while BUSY are ignored; the pipeline stalls MD instructions until DONE.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (bus.md_cancel) begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.ex_md_start) begin
                        state_nx = S_BUSY;
                        cnt_nx   = bus.ex_md_is_div ? DIV_LOAD : MULT_LOAD;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end
                S_BUSY: begin
                    if (cnt == '0) state_nx = S_DONE;
                    else           cnt_nx   = cnt - 1'b1;
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         stall_cnt <= '0;
        else if (stall && stall_cnt != '1)  stall_cnt <= stall_cnt + 1'b1;
    end
endmodule
